// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bundle between the memory stage and data memory.
interface mem_access_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      output dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I memory stage: data-memory handshake with timeout, lane steering, MEM/WB register.
// Optional macro MISALIGN_TRAP_EN traps misaligned H/W accesses and adds MisalignW.
module mem_access_stage #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       RegWriteM,
   input  logic                       MemWriteM,
   input  logic [1:0]                 ResultSrcM,
   input  logic [2:0]                 Funct3M,
   input  logic [4:0]                 RD_M,
   input  logic [31:0]                PCPlus4M,
   input  logic [31:0]                ALU_ResultM,
   input  logic [31:0]                WriteDataM,
   mem_access_stage_if.master         dmem,
   output logic                       StallM,
   output logic                       RegWriteW,
   output logic [1:0]                 ResultSrcW,
   output logic [4:0]                 RD_W,
   output logic [31:0]                PCPlus4W,
   output logic [31:0]                ALU_ResultW,
   output logic [31:0]                ReadDataW,
`ifdef MISALIGN_TRAP_EN
   output logic                       MisalignW,
`endif
   output logic                       BusErrW
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t          r_state;
   logic [TO_W-1:0] r_cnt;

   logic        w_mem_op;
   logic        w_misalign;
   logic        w_access;
   logic        w_timeout;
   logic [1:0]  w_off;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [3:0]  w_strb;
   logic [31:0] w_wdata;

   assign w_off    = ALU_ResultM[1:0];
   assign w_mem_op = MemWriteM | (ResultSrcM == 2'b01);

`ifdef MISALIGN_TRAP_EN
   assign w_misalign = w_mem_op & (((Funct3M[1:0] == 2'b01) & w_off[0]) |
                                   ((Funct3M[1:0] == 2'b10) & (w_off != 2'b00)));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_access  = w_mem_op & ~w_misalign;
   assign w_timeout = (r_state == WAIT) & w_access & ~dmem.dmem_ready &
                      (r_cnt == TO_W'(TIMEOUT_CYCLES));

   // Request and stall are gated by reset so a pending access is withdrawn asynchronously.
   assign dmem.dmem_req   = reset & w_access & ~w_timeout;
   assign StallM          = reset & w_access & ~dmem.dmem_ready & ~w_timeout;
   assign dmem.dmem_we    = MemWriteM;
   assign dmem.dmem_addr  = {ALU_ResultM[31:2], 2'b00};
   assign dmem.dmem_wdata = w_wdata;
   assign dmem.dmem_wstrb = (reset & MemWriteM & w_access) ? w_strb : 4'b0000;

   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      w_strb  = 4'b1111;
      w_wdata = WriteDataM;
      case (Funct3M[1:0])
         2'b00: begin
            w_strb  = 4'b0001 << w_off;
            w_wdata = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            w_strb  = w_off[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{WriteDataM[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_byte = dmem.dmem_rdata[{w_off, 3'b000} +: 8];
   assign w_half = w_off[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

   always_comb begin
      w_load = dmem.dmem_rdata;
      case (Funct3M)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load = {24'b0, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b101:  w_load = {16'b0, w_half};
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_access & ~dmem.dmem_ready) begin
                  r_state <= WAIT;
                  r_cnt   <= TO_W'(1);
               end
            end
            WAIT: begin
               if (dmem.dmem_ready | ~w_access | w_timeout) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + TO_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         RegWriteW   <= 1'b0;
         ResultSrcW  <= 2'b00;
         RD_W        <= 5'd0;
         PCPlus4W    <= 32'd0;
         ALU_ResultW <= 32'd0;
         ReadDataW   <= 32'd0;
         BusErrW     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         MisalignW   <= 1'b0;
`endif
      end else if (StallM) begin
         // Bubble into writeback; the data fields simply hold.
         RegWriteW <= 1'b0;
         RD_W      <= 5'd0;
         BusErrW   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         MisalignW <= 1'b0;
`endif
      end else begin
         RegWriteW   <= RegWriteM & ~w_timeout & ~w_misalign;
         ResultSrcW  <= ResultSrcM;
         RD_W        <= RD_M;
         PCPlus4W    <= PCPlus4M;
         ALU_ResultW <= ALU_ResultM;
         ReadDataW   <= w_timeout ? 32'd0 : w_load;
         BusErrW     <= w_timeout;
`ifdef MISALIGN_TRAP_EN
         MisalignW   <= w_misalign;
`endif
      end
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage RV32I pipeline. Consumes the EX/MEM pipeline register outputs of the execute stage.
- Runs loads and stores to data memory over a req/ready handshake with variable latency. Raises a stall while an access is outstanding.
- Performs byte/half lane steering, sign/zero extension and the MEM/WB pipeline register.
- Non-memory instructions pass through to writeback with one cycle of latency.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for dmem_ready before the access is abandoned with BusErrW.
- TO_W, 8: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- RegWriteM  in  1  register-file write enable, from EX/MEM
- MemWriteM  in  1  store
- ResultSrcM  in  2  00=ALU, 01=load, 10=PC+4
- Funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- RD_M  in  5  destination register
- PCPlus4M  in  32  link value
- ALU_ResultM  in  32  effective address or ALU result
- WriteDataM  in  32  store data (already forwarded)
- dmem_req  out  1  access request
- dmem_we  out  1  write enable
- dmem_addr  out  32  word address; [1:0] always 00
- dmem_wdata  out  32  lane-steered store data
- dmem_wstrb  out  4  byte strobes
- dmem_ready  in  1  access complete; dmem_rdata valid in the same cycle for reads
- dmem_rdata  in  32  read word
- StallM  out  1  hold IF/ID/EX/MEM registers
- RegWriteW  out  1
- ResultSrcW  out  2
- RD_W  out  5
- PCPlus4W  out  32
- ALU_ResultW  out  32
- ReadDataW  out  32  extended load data
- BusErrW  out  1  one-cycle flag: access timed out

Behaviour:
- Memory op definition: mem_op = MemWriteM | (ResultSrcM==01).
- Reset (reset=0, asynchronous):
  - State IDLE, counter 0.
  - All W outputs 0 and BusErrW 0.
  - dmem_req, StallM and dmem_wstrb are 0 while reset is held.
- FSM states:
  - IDLE:
    - dmem_req = mem_op, driven combinationally.
    - If mem_op & ~dmem_ready, go to WAIT and load the counter with 1.
    - Zero-wait completion (dmem_ready in the same cycle) stays in IDLE.
  - WAIT:
    - dmem_req stays 1; address, data, strobes and dmem_we are held stable.
    - On dmem_ready, go to IDLE.
    - Otherwise increment the counter. On counter == TIMEOUT_CYCLES, go to IDLE with a timeout flag for that cycle.
- StallM = mem_op & ~dmem_ready & ~timeout.
- dmem_we = MemWriteM.
- Store lane steering uses offset off = ALU_ResultM[1:0]:
  - B: strobe 0001<<off; wdata = {4{byte}}.
  - H: strobe 0011<<(off[1]*2); wdata = {2{half}}.
  - W: strobe 1111.
  - dmem_wstrb = 0 on loads.
- Load extraction from dmem_rdata:
  - Select the byte or half at the offset.
  - Sign-extend for B/H; zero-extend for BU/HU; W is taken as-is.
- MEM/WB register update, every clock:
  - While StallM=1: load a bubble (RegWriteW=0, RD_W=0). Other W fields are don't-care but must be deterministic: hold their values.
  - Otherwise: capture all M fields and ReadDataW.
- Timeout completion:
  - RegWriteW forced 0 and ReadDataW=0.
  - BusErrW=1 for exactly one cycle.
  - The store is dropped.
- Non-memory ops: no request issued, zero stall, one-cycle latency M to W.
- Back-to-back memory ops: the next op is issued the cycle after completion; no idle gap is required.
- Reset mid-access: dmem_req drops asynchronously, WAIT is abandoned and no W writeback occurs. The memory side must tolerate the withdrawn request.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A H access with off[0]=1, or a W access with off!=0, is misaligned.
  - No dmem_req is issued and there is no stall.
  - The W stage receives RegWriteW=0, plus a 1-bit output MisalignW=1 for one cycle. MisalignW exists only when the macro is defined.
- Undefined:
  - Offending low address bits are ignored: H uses off[1] only; W ignores off.
  - The access proceeds as if aligned.

Test Plan:
1. Zero-wait load: LW at 0x100, rdata=0xDEADBEEF with dmem_ready in the same cycle -> StallM never asserts; next cycle ReadDataW=0xDEADBEEF, RegWriteW=1.
2. Wait-state LB:
   - Stimulus: addr 0x203, ready after 3 cycles, rdata=0x80000000.
   - StallM=1 for 3 cycles and dmem_addr stays 0x200 throughout.
   - W stage sees bubbles, then ReadDataW=0xFFFFFF80.
3. SH at 0x102 with WriteDataM=0x1234ABCD -> dmem_wstrb=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
4. Timeout: load with dmem_ready held 0 and TIMEOUT_CYCLES=4 -> StallM high 4 cycles, then BusErrW pulses once with RegWriteW=0.
5. ALU op followed by LHU: ALU op with RD_M=5 passes through in 1 cycle; the following LHU at 0x2 with rdata 0xF00D0000 -> ReadDataW=0x0000F00D.
6. Reset asserted in WAIT -> dmem_req and StallM drop immediately and all W outputs are 0. With MISALIGN_TRAP_EN defined, LW at 0x101 gives MisalignW=1 and no dmem_req.
